alu_requester: RTL and testbench
================================

ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit, request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit, request accepted when both req_valid and req_ready are high at a rising edge.
REQ-006 The block SHALL have port req_op, input, 3 bits, operation code (REQ-013).
REQ-007 The block SHALL have ports req_a and req_b, input, 32 bits each, operands.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit, response present.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit, response popped when both rsp_valid and rsp_ready are high at a rising edge.
REQ-010 The block SHALL have ports rsp_result (output, 32 bits), rsp_zero, rsp_taken and rsp_err (output, 1 bit each), holding the head response fields.
REQ-011 The block SHALL have ports alu_src1 and alu_src2 (output, 32 bits), alu_ctr (output, 3 bits), alu_result (input, 32 bits) and zero_bit (input, 1 bit), connecting to the combinational ALU.
REQ-012 The block SHALL have port op_count, output, CNT_W bits, number of responses pushed since reset.

Function
REQ-013 req_op SHALL map to alu_ctr and response fields as follows:
- 000 ADD -> alu_ctr 010
- 001 SUB -> 110
- 010 AND -> 000
- 011 OR -> 001
- 100 SLT -> 111
- 101 BEQ -> 110, rsp_taken=zero_bit
- 110 BNE -> 110, rsp_taken=~zero_bit
- 111 illegal
- rsp_taken SHALL be 0 for all non-branch ops.
REQ-014 The FSM SHALL have two states: IDLE and ISSUE.
- IDLE -> ISSUE on an accepted request; op and operands latched into internal registers.
- ISSUE -> IDLE always, after exactly one cycle.
REQ-015 In ISSUE, alu_src1/alu_src2/alu_ctr SHALL be driven from the latched registers, and at the end of ISSUE {alu_result, zero_bit, taken, err=0} SHALL be pushed into the response FIFO.
REQ-016 In IDLE, alu_src1=0, alu_src2=0 and alu_ctr=000 SHALL be driven.
REQ-017 An illegal op SHALL still pass through ISSUE with ALU outputs as in IDLE, and SHALL push result=0, zero=1, taken=0, err=1.
REQ-018 The response FIFO SHALL be 2 entries deep and first-in first-out; rsp_* fields SHALL show the head entry; rsp_valid SHALL equal (count!=0).
REQ-019 req_ready SHALL be (state==IDLE) && (count<2), combinationally from registered state; no request SHALL be accepted during ISSUE.
REQ-020 Latency SHALL be accept at edge N, push at edge N+1, and rsp_valid high after edge N+1 when the FIFO was empty; maximum throughput is one request per 2 cycles.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and the order intact; a pop from an empty FIFO SHALL be ignored.
REQ-022 op_count SHALL increment by 1 per push, including illegal ops, and SHALL wrap from all-ones to 0.

Reset
REQ-023 On Reset high at an edge, the block SHALL set state=IDLE, FIFO count=0, FIFO storage=0, op_count=0 and latched registers=0, giving req_ready=1, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_taken=0, rsp_err=0 and alu outputs=0.
REQ-024 Reset SHALL take priority over every other event, including mid-ISSUE: the in-flight operation SHALL be discarded and not pushed.

Verification
REQ-025 ADD 5+7 with rsp_ready=1 -> rsp_valid one cycle after accept, rsp_result=12, rsp_zero=0, rsp_taken=0, rsp_err=0, op_count=1.
REQ-026 BEQ 9,9, then BNE 9,9, then SLT 3,8 -> responses taken=1/zero=1/result=0; taken=0/zero=1; result=1/taken=0.
REQ-027 rsp_ready=0 with three back-to-back requests -> two accepted, req_ready=0 with the third pending; raising rsp_ready pops the first and the third is accepted the next cycle, in order.
REQ-028 req_op=111 -> alu_ctr stays 000, response err=1, result=0, zero=1, and op_count increments.
REQ-029 Reset asserted in the ISSUE cycle of SUB 4-4 -> no response, op_count=0, req_ready=1 on the following cycle.

Source files
------------

// File: rtl/alu_requester.sv
// ============================================================================
// alu_requester : drives a combinational ALU and queues its results in a 2-deep FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_requester #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [2:0]       alu_ctr,
  input  logic [31:0]      alu_result,
  input  logic             zero_bit,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_SLT = 3'b100;
  localparam logic [2:0] c_OP_BEQ = 3'b101;
  localparam logic [2:0] c_OP_BNE = 3'b110;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  // Entry layout: {result[31:0], zero, taken, err}
  logic [34:0]       r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [34:0]       w_push_data;

  assign req_ready = (r_state == IDLE) && (r_count < 2'd2);
  assign w_accept  = req_valid && req_ready;
  assign w_push    = (r_state == ISSUE);
  assign w_pop     = rsp_ready && (r_count != 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    alu_src1    = 32'd0;
    alu_src2    = 32'd0;
    alu_ctr     = 3'b000;
    w_push_data = 35'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_state_nxt = IDLE;
        alu_src1    = r_a;
        alu_src2    = r_b;
        w_push_data = {alu_result, zero_bit, 1'b0, 1'b0};
        case (r_op)
          c_OP_ADD: alu_ctr = 3'b010;
          c_OP_SUB: alu_ctr = 3'b110;
          c_OP_AND: alu_ctr = 3'b000;
          c_OP_OR:  alu_ctr = 3'b001;
          c_OP_SLT: alu_ctr = 3'b111;
          c_OP_BEQ: begin
            alu_ctr     = 3'b110;
            w_push_data = {alu_result, zero_bit, zero_bit, 1'b0};
          end
          c_OP_BNE: begin
            alu_ctr     = 3'b110;
            w_push_data = {alu_result, zero_bit, ~zero_bit, 1'b0};
          end
          default: begin
            // Illegal op: keep the ALU quiet and report an error entry
            alu_src1    = 32'd0;
            alu_src2    = 32'd0;
            w_push_data = {32'd0, 1'b1, 1'b0, 1'b1};
          end
        endcase
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_op       <= 3'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_mem[0]   <= 35'd0;
      r_mem[1]   <= 35'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op <= req_op;
        r_a  <= req_a;
        r_b  <= req_b;
      end
      if (w_push) begin
        r_mem[r_wptr] <= w_push_data;
        r_wptr        <= ~r_wptr;
        r_op_count    <= r_op_count + 1'b1;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = (r_count != 2'd0);
  assign {rsp_result, rsp_zero, rsp_taken, rsp_err} = r_mem[r_rptr];
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_requester.sv
// ============================================================================
// tb_alu_requester : directed self-checking bench with a behavioural ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_requester;

  localparam int CNT_W = 4;

  logic             Clk;
  logic             Reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_taken;
  logic             rsp_err;
  logic [31:0]      alu_src1;
  logic [31:0]      alu_src2;
  logic [2:0]       alu_ctr;
  logic [31:0]      alu_result;
  logic             zero_bit;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_requester #(.CNT_W(CNT_W)) u_dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_taken  (rsp_taken),
    .rsp_err    (rsp_err),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctr    (alu_ctr),
    .alu_result (alu_result),
    .zero_bit   (zero_bit),
    .op_count   (op_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural combinational ALU attached to the requester
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctr)
      3'b010:  alu_result = alu_src1 + alu_src2;
      3'b110:  alu_result = alu_src1 - alu_src2;
      3'b000:  alu_result = alu_src1 & alu_src2;
      3'b001:  alu_result = alu_src1 | alu_src2;
      3'b111:  alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    zero_bit = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE; returns at the negedge after the push edge
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] exp_ctr, input logic [31:0] exp_s1,
                        input logic [31:0] exp_s2);
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge Clk);
    req_valid = 1'b0;
    check("issue_req_ready", req_ready, 0);
    check("issue_alu_ctr", alu_ctr, exp_ctr);
    check("issue_alu_src1", alu_src1, exp_s1);
    check("issue_alu_src2", alu_src2, exp_s2);
    @(negedge Clk);
  endtask

  task automatic pop_rsp(input string tag, input logic [31:0] res, input logic zero,
                         input logic taken, input logic err);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_result"}, rsp_result, res);
    check({tag, "_zero"}, rsp_zero, zero);
    check({tag, "_taken"}, rsp_taken, taken);
    check({tag, "_err"}, rsp_err, err);
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_rsp_taken", rsp_taken, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_src1", alu_src1, 0);
    check("rst_alu_src2", alu_src2, 0);
    check("rst_alu_ctr", alu_ctr, 0);
    check("rst_op_count", op_count, 0);

    // ADD 5+7 with the consumer always ready
    rsp_ready = 1'b1;
    do_req(3'b000, 32'd5, 32'd7, 3'b010, 32'd5, 32'd7);
    check("add_valid", rsp_valid, 1);
    check("add_result", rsp_result, 12);
    check("add_zero", rsp_zero, 0);
    check("add_taken", rsp_taken, 0);
    check("add_err", rsp_err, 0);
    check("add_op_count", op_count, 1);
    @(negedge Clk);
    check("add_popped", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Branches and compare
    do_req(3'b101, 32'd9, 32'd9, 3'b110, 32'd9, 32'd9);
    pop_rsp("beq", 32'd0, 1'b1, 1'b1, 1'b0);
    do_req(3'b110, 32'd9, 32'd9, 3'b110, 32'd9, 32'd9);
    pop_rsp("bne", 32'd0, 1'b1, 1'b0, 1'b0);
    do_req(3'b100, 32'd3, 32'd8, 3'b111, 32'd3, 32'd8);
    pop_rsp("slt", 32'd1, 1'b0, 1'b0, 1'b0);
    do_req(3'b010, 32'hFF00FF00, 32'h0FF00FF0, 3'b000, 32'hFF00FF00, 32'h0FF00FF0);
    pop_rsp("and", 32'h0F000F00, 1'b0, 1'b0, 1'b0);
    check("op_count_5", op_count, 5);

    // Back-to-back requests against a stalled consumer
    req_valid = 1'b1;
    req_op = 3'b000; req_a = 32'd1; req_b = 32'd1;
    @(negedge Clk);
    check("b2b_a_issue_ready", req_ready, 0);
    req_op = 3'b001; req_a = 32'd10; req_b = 32'd3;
    @(negedge Clk);
    check("b2b_after_a_ready", req_ready, 1);
    @(negedge Clk);
    check("b2b_b_issue_ready", req_ready, 0);
    req_op = 3'b011; req_a = 32'h000000F0; req_b = 32'h0000000F;
    @(negedge Clk);
    check("b2b_full_ready", req_ready, 0);
    check("b2b_head_a", rsp_result, 2);
    @(negedge Clk);
    check("b2b_full_ready_hold", req_ready, 0);
    check("b2b_op_count", op_count, 7);
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    check("b2b_head_b", rsp_result, 7);
    check("b2b_c_ready", req_ready, 1);
    @(negedge Clk);
    req_valid = 1'b0;
    check("b2b_c_issue_ready", req_ready, 0);
    check("b2b_c_issue_ctr", alu_ctr, 3'b001);
    rsp_ready = 1'b1;
    @(negedge Clk);
    check("pushpop_valid", rsp_valid, 1);
    check("pushpop_head_c", rsp_result, 32'hFF);
    @(negedge Clk);
    check("pushpop_drained", rsp_valid, 0);
    @(negedge Clk);
    check("empty_pop_valid", rsp_valid, 0);
    check("empty_pop_ready", req_ready, 1);
    rsp_ready = 1'b0;

    // Illegal opcode
    do_req(3'b111, 32'h1234, 32'h5678, 3'b000, 32'd0, 32'd0);
    pop_rsp("illegal", 32'd0, 1'b1, 1'b0, 1'b1);
    check("illegal_op_count", op_count, 9);

    // Counter wrap (CNT_W = 4)
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_req(3'b000, i, 32'd1, 3'b010, i, 32'd1);
      check("wrap_loop_result", rsp_result, i + 1);
    end
    check("wrap_count_15", op_count, 15);
    do_req(3'b000, 32'd0, 32'd0, 3'b010, 32'd0, 32'd0);
    check("wrap_count_0", op_count, 0);
    @(negedge Clk);
    check("wrap_drained", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Reset during ISSUE discards the operation
    req_valid = 1'b1;
    req_op = 3'b001; req_a = 32'd4; req_b = 32'd4;
    @(negedge Clk);
    check("midrst_in_issue", req_ready, 0);
    req_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_alu_ctr", alu_ctr, 0);
    @(negedge Clk);
    check("midrst_rsp_valid_later", rsp_valid, 0);
    check("midrst_op_count_later", op_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
